fifo_stream_adapter: RTL and testbench

FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

---
 rtl/fifo_stream_adapter.sv | 106 ++++++++++
 tb/tb_fifo_stream_adapter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter
//   Bridges a one-cycle-latency upstream FIFO read port to a valid/ready
//   downstream stream. A two-entry register queue soaks up the pop latency,
//   so the stream can run at one word per cycle. fifo_rd_en follows m_ready
//   combinationally.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset
//   fifo_empty  upstream FIFO empty flag
//   fifo_rd_en  pop request to the upstream FIFO
//   fifo_data   upstream read data, valid the cycle after a pop
//   flush       discard all buffered and in-flight words
//   m_valid     downstream word valid
//   m_ready     downstream accept
//   m_data      downstream word (head of the queue)
//   buf_count   words held in the output queue (0..2)
//   beat_cnt    accepted downstream beats, wraps modulo 2^CNT_WIDTH
module fifo_stream_adapter #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            buf_count,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  logic                  inflight_p1;
  logic [1:0]            count_p2;
  logic [DATA_WIDTH-1:0] head_p2;
  logic [DATA_WIDTH-1:0] tail_p2;
  logic                  pop;
  logic                  arrive;
  logic [2:0]            occupancy;

  assign pop    = m_valid && m_ready;
  // A word landing in the flush cycle is dropped, not appended.
  assign arrive = inflight_p1 && !flush;

  // Words already committed to the queue once this cycle's pop is taken out.
  // count + inflight >= pop always holds (pop needs count >= 1).
  assign occupancy  = {1'b0, count_p2} + {2'b00, inflight_p1} - {2'b00, pop};
  assign fifo_rd_en = !rst && !flush && !fifo_empty && (occupancy < 3'd2);

  assign m_valid   = (count_p2 != 2'd0) && !flush && !rst;
  assign m_data    = head_p2;
  assign buf_count = count_p2;

  // Stage p1: pop issued last cycle, data present on fifo_data now
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_p1 <= 1'b0;
    end else begin
      // fifo_rd_en is forced low during flush, so this also clears on flush.
      inflight_p1 <= fifo_rd_en;
    end
  end

  // Stage p2: output queue occupancy and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p2 <= 2'd0;
      beat_cnt <= '0;
    end else begin
      if (flush) begin
        count_p2 <= 2'd0;
      end else begin
        count_p2 <= count_p2 + {1'b0, arrive} - {1'b0, pop};
      end
      if (pop) begin
        beat_cnt <= beat_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      assert (!(arrive && !pop && count_p2 == 2'd2))
        else $error("fifo_stream_adapter: arrival into a full output queue");
    end
  end

  // Queue storage carries no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    case ({pop, arrive})
      2'b10: head_p2 <= tail_p2;
      2'b01: begin
        if (count_p2 == 2'd0) head_p2 <= fifo_data;
        else                  tail_p2 <= fifo_data;
      end
      2'b11: begin
        if (count_p2 == 2'd1) begin
          head_p2 <= fifo_data;
        end else begin
          head_p2 <= tail_p2;
          tail_p2 <= fifo_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
module tb_fifo_stream_adapter;

  localparam int DW = 64;
  localparam int CW = 32;

  logic          clk;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    buf_count;
  logic [CW-1:0] beat_cnt;

  fifo_stream_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .buf_count  (buf_count),
    .beat_cnt   (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            pops = 0;
  int            dropped = 0;
  int            ready_pct = 100;
  int            gap_pct = 0;
  logic          rst_req = 1'b1;
  logic [CW-1:0] beat_exp = '0;
  logic [DW-1:0] src[$];
  logic [DW-1:0] exp_q[$];
  logic          obs_rd;
  logic          obs_valid;
  logic [DW-1:0] obs_data;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic apply_inputs();
    rst        = rst_req;
    flush      = 1'b0;
    m_ready    = (int'($urandom_range(99)) < ready_pct);
    fifo_empty = (src.size() == 0) || (int'($urandom_range(99)) < gap_pct);
  endtask

  // One clock cycle: sample at negedge, model the upstream FIFO after posedge.
  task automatic cycle();
    @(negedge clk);
    obs_rd    = fifo_rd_en;
    obs_valid = m_valid;
    obs_data  = m_data;
    chk("rd_while_empty", fifo_rd_en & fifo_empty, 0);
    if (cyc > 0) chk("buf_count_max", buf_count <= 2'd2, 1);
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      pops++;
      beat_exp++;
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("order", m_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (rst) beat_exp = '0;
    if (rst || flush) begin
      dropped = exp_q.size();
      exp_q.delete();
    end
    if (obs_rd && src.size() > 0) begin
      fifo_data = src.pop_front();
      exp_q.push_back(fifo_data);
    end else begin
      fifo_data = 64'hDEAD_DEAD_DEAD_DEAD;
    end
    cyc++;
    chk("beat_cnt", beat_cnt, beat_exp);
    apply_inputs();
  endtask

  initial begin
    int n;
    int guard;
    int pops_start;
    logic [CW-1:0] beat_before;
    logic [DW-1:0] first_data;
    logic          seen;

    fifo_data = 64'hDEAD_DEAD_DEAD_DEAD;
    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
    rst_req = 1'b1;
    apply_inputs();

    // Reset held two cycles with upstream non-empty
    cycle();
    chk("rst_rd", obs_rd, 0);
    chk("rst_valid", obs_valid, 0);
    rst_req = 1'b0;
    cycle();
    chk("rst_rd2", obs_rd, 0);
    chk("rst_valid2", obs_valid, 0);
    chk("rst_buf_count", buf_count, 0);
    chk("rst_beat_cnt", beat_cnt, 0);

    // Streaming 1..8 with m_ready=1
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("stream_rd", obs_rd, (i < 8) ? 1 : 0);
      chk("stream_valid", obs_valid, (i >= 2) ? 1 : 0);
      if (i >= 2) chk("stream_data", obs_data, 64'(i - 1));
    end
    chk("stream_beats", beat_cnt, 8);
    chk("stream_sb_empty", exp_q.size(), 0);

    // Backpressure: only two pops, head held
    for (int i = 0; i < 6; i++) src.push_back(64'h11 + 64'(i));
    ready_pct = 0;
    apply_inputs();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (obs_rd) n++;
      if (i >= 2) begin
        chk("bp_valid", obs_valid, 1);
        chk("bp_hold_data", obs_data, 64'h11);
      end
    end
    chk("bp_rd_pulses", n, 2);
    chk("bp_buf_count", buf_count, 2);
    ready_pct = 100;
    apply_inputs();
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("bp_drain_valid", obs_valid, 1);
      chk("bp_drain_data", obs_data, 64'h11 + 64'(i));
    end
    cycle();
    chk("bp_drained", obs_valid, 0);

    // Single word after a long empty period
    ready_pct = 0;
    apply_inputs();
    for (int i = 0; i < 8; i++) cycle();
    src.push_back(64'h77);
    apply_inputs();
    cycle();
    chk("single_rd", obs_rd, 1);
    cycle();
    chk("single_rd_once", obs_rd, 0);
    chk("single_valid_early", obs_valid, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("single_valid_held", obs_valid, 1);
      chk("single_data", obs_data, 64'h77);
      chk("single_no_rd", obs_rd, 0);
    end
    ready_pct = 100;
    apply_inputs();
    cycle();
    chk("single_pop_valid", obs_valid, 1);
    cycle();
    chk("single_after_pop", obs_valid, 0);

    // Flush with a full output queue
    for (int i = 0; i < 6; i++) src.push_back(64'h31 + 64'(i));
    ready_pct = 0;
    apply_inputs();
    for (int i = 0; i < 4; i++) cycle();
    chk("flushA_pre_count", buf_count, 2);
    beat_before = beat_cnt;
    flush = 1'b1;
    cycle();
    chk("flushA_valid_in", obs_valid, 0);
    chk("flushA_rd_in", obs_rd, 0);
    chk("flushA_count", buf_count, 0);
    chk("flushA_valid", m_valid, 0);
    chk("flushA_dropped", dropped, 2);
    chk("flushA_beats", beat_cnt, beat_before);
    ready_pct = 100;
    apply_inputs();
    seen = 1'b0;
    first_data = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (obs_valid && !seen) begin
        seen = 1'b1;
        first_data = obs_data;
      end
    end
    chk("flushA_resume", first_data, 64'h33);

    // Flush mid-stream: one word buffered, one arriving
    for (int i = 0; i < 8; i++) src.push_back(64'h41 + 64'(i));
    apply_inputs();
    for (int i = 0; i < 4; i++) cycle();
    chk("flushB_pre_count", buf_count, 1);
    chk("flushB_pre_rd", obs_rd, 1);
    beat_before = beat_cnt;
    flush = 1'b1;
    cycle();
    chk("flushB_valid_in", obs_valid, 0);
    chk("flushB_count", buf_count, 0);
    chk("flushB_dropped", dropped, 2);
    chk("flushB_beats", beat_cnt, beat_before);
    seen = 1'b0;
    first_data = '0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_valid && !seen) begin
        seen = 1'b1;
        first_data = obs_data;
      end
    end
    chk("flushB_resume", first_data, 64'h45);
    chk("flushB_sb_empty", exp_q.size(), 0);

    // Reset mid-transfer
    for (int i = 0; i < 6; i++) src.push_back(64'h51 + 64'(i));
    ready_pct = 0;
    apply_inputs();
    for (int i = 0; i < 4; i++) cycle();
    rst_req = 1'b1;
    apply_inputs();
    rst_req = 1'b0;
    cycle();
    chk("midrst_rd", obs_rd, 0);
    chk("midrst_valid", obs_valid, 0);
    chk("midrst_count", buf_count, 0);
    chk("midrst_beats", beat_cnt, 0);
    ready_pct = 100;
    apply_inputs();
    seen = 1'b0;
    first_data = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (obs_valid && !seen) begin
        seen = 1'b1;
        first_data = obs_data;
      end
    end
    chk("midrst_resume", first_data, 64'h53);

    // 1000 random words, random backpressure and empty gaps
    for (int i = 0; i < 1000; i++) src.push_back({$urandom, $urandom});
    beat_before = beat_cnt;
    ready_pct = 50;
    gap_pct = 30;
    apply_inputs();
    pops_start = pops;
    guard = 0;
    while ((pops - pops_start) < 1000 && guard < 20000) begin
      cycle();
      guard++;
    end
    chk("rand_timeout", guard < 20000, 1);
    chk("rand_pops", pops - pops_start, 1000);
    chk("rand_beats", beat_cnt - beat_before, 1000);
    chk("rand_sb_empty", exp_q.size(), 0);
    chk("rand_src_empty", src.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
